// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode-to-issue handshake between the instruction decoder and the hazard scoreboard.
// master = decoder side, slave = scoreboard controller.
interface hazard_scoreboard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             dec_valid;
   logic [4:0]       dec_rs1_sel;
   logic [4:0]       dec_rs2_sel;
   logic             dec_rs1_used;
   logic             dec_rs2_used;
   logic [4:0]       dec_rd_sel;
   logic             dec_wen;
   logic             flush;
   logic             stall;
   logic             issue;
   logic             bubble;
   logic [31:0]      pending_mask;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output dec_valid, dec_rs1_sel, dec_rs2_sel, dec_rs1_used, dec_rs2_used,
             dec_rd_sel, dec_wen, flush,
      input  stall, issue, bubble, pending_mask, stall_count
   );

   modport slave (
      input  dec_valid, dec_rs1_sel, dec_rs2_sel, dec_rs1_used, dec_rs2_used,
             dec_rd_sel, dec_wen, flush,
      output stall, issue, bubble, pending_mask, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// In-order issue scoreboard: tracks in-flight destination registers for LAT cycles
// and stalls decode on read-after-write hazards. Never touches operand data.
module hazard_scoreboard_ctrl #(
   parameter int LAT   = 2,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   hazard_scoreboard_ctrl_if.slave sb
);
   logic [LAT-1:0]   slot_v;
   logic [4:0]       slot_rd [LAT];
   logic [31:0]      pend;
   logic             hazard;
   logic             stall_c;
   logic             issue_c;
   logic [CNT_W-1:0] cnt;

   // The register file is not write-through, so the retiring slot still counts.
   always_comb begin
      pend = '0;
      for (int i = 0; i < LAT; i++) begin
         if (slot_v[i]) pend[slot_rd[i]] = 1'b1;
      end
      pend[0] = 1'b0;
   end

   always_comb begin
      hazard = (sb.dec_rs1_used && (sb.dec_rs1_sel != 5'd0) && pend[sb.dec_rs1_sel]) ||
               (sb.dec_rs2_used && (sb.dec_rs2_sel != 5'd0) && pend[sb.dec_rs2_sel]);
      stall_c = sb.dec_valid && hazard && !sb.flush;
      issue_c = sb.dec_valid && !hazard && !sb.flush;
   end

   assign sb.stall        = stall_c;
   assign sb.issue        = issue_c;
   assign sb.bubble       = !issue_c;
   assign sb.pending_mask = pend;
   assign sb.stall_count  = cnt;

   // A flush kills the youngest in-flight entry as it moves into slot 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_v <= '0;
         for (int i = 0; i < LAT; i++) slot_rd[i] <= 5'd0;
         cnt <= '0;
      end else begin
         slot_v[0]  <= issue_c && sb.dec_wen && (sb.dec_rd_sel != 5'd0);
         slot_rd[0] <= sb.dec_rd_sel;
         for (int i = 1; i < LAT; i++) begin
            slot_v[i]  <= (i == 1 && sb.flush) ? 1'b0 : slot_v[i-1];
            slot_rd[i] <= slot_rd[i-1];
         end
         if (stall_c && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Directed bench for hazard_scoreboard_ctrl (LAT=2, CNT_W=4) with an expected-result queue.
module tb_hazard_scoreboard_ctrl;
   localparam int LAT   = 2;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic             stall;
      logic             issue;
      logic             bubble;
      logic [31:0]      mask;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   exp_t exp_q[$];
   logic [CNT_W-1:0] exp_cnt;

   hazard_scoreboard_ctrl_if #(.CNT_W(CNT_W)) sif ();

   hazard_scoreboard_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .sb  (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic fl);
      sif.dec_valid    = v;
      sif.dec_rs1_sel  = rs1;
      sif.dec_rs1_used = u1;
      sif.dec_rs2_sel  = rs2;
      sif.dec_rs2_used = u2;
      sif.dec_rd_sel   = rd;
      sif.dec_wen      = wen;
      sif.flush        = fl;
   endtask

   task automatic push_exp(input logic e_stall, input logic [31:0] e_mask,
                           input logic [CNT_W-1:0] e_cnt);
      exp_t e;
      e.stall  = e_stall;
      e.issue  = sif.dec_valid && !e_stall && !sif.flush;
      e.bubble = !e.issue;
      e.mask   = e_mask;
      e.cnt    = e_cnt;
      exp_q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      e = exp_q.pop_front();
      total++;
      assert (sif.stall === e.stall) else begin
         bad++; $error("FAIL %s stall got=%0b exp=%0b", tag, sif.stall, e.stall);
      end
      total++;
      assert (sif.issue === e.issue) else begin
         bad++; $error("FAIL %s issue got=%0b exp=%0b", tag, sif.issue, e.issue);
      end
      total++;
      assert (sif.bubble === e.bubble) else begin
         bad++; $error("FAIL %s bubble got=%0b exp=%0b", tag, sif.bubble, e.bubble);
      end
      total++;
      assert (sif.pending_mask === e.mask) else begin
         bad++; $error("FAIL %s pending_mask got=%h exp=%h", tag, sif.pending_mask, e.mask);
      end
      total++;
      assert (sif.stall_count === e.cnt) else begin
         bad++; $error("FAIL %s stall_count got=%0d exp=%0d", tag, sif.stall_count, e.cnt);
      end
   endtask

   // One pipeline cycle: drive after the edge, check mid-cycle, advance to the next edge.
   task automatic step(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wen, input logic fl,
                       input logic e_stall, input logic [31:0] e_mask,
                       input logic [CNT_W-1:0] e_cnt, input string tag);
      drive(v, rs1, u1, rs2, u2, rd, wen, fl);
      push_exp(e_stall, e_mask, e_cnt);
      @(negedge clk);
      check_out(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #3;
      push_exp(1'b0, 32'h0, 4'd0);
      check_out("reset_state");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // RAW on rd=5: two stall cycles, then issue
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0,       4'd0, "raw_prod");
      step(1, 5, 1, 0, 0, 6, 1, 0, 1, 32'h1 << 5,  4'd0, "raw_stall1");
      step(1, 5, 1, 0, 0, 6, 1, 0, 1, 32'h1 << 5,  4'd1, "raw_stall2");
      step(1, 5, 1, 0, 0, 6, 1, 0, 0, 32'h0,       4'd2, "raw_issue");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 6,  4'd2, "raw_drain1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 6,  4'd2, "raw_drain2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       4'd2, "raw_empty");

      // Asynchronous reset while a dependent instruction is stalling
      step(1, 0, 0, 0, 0, 5, 1, 0, 0, 32'h0,       4'd2, "rst_prod");
      drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      push_exp(1'b1, 32'h1 << 5, 4'd2);
      check_out("rst_pre");
      rst = 1'b1;
      #1;
      push_exp(1'b0, 32'h0, 4'd0);
      check_out("rst_async");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // x0 destination/source and unused operands
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0,       4'd0, "x0_wr");
      step(1, 0, 1, 0, 0, 9, 1, 0, 0, 32'h0,       4'd0, "x0_rd");
      step(1, 0, 0, 9, 0, 0, 0, 0, 0, 32'h1 << 9,  4'd0, "unused_rs2_a");
      step(1, 0, 0, 9, 0, 0, 0, 0, 0, 32'h1 << 9,  4'd0, "unused_rs2_b");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       4'd0, "x0_empty");

      // Two writes to the same register tracked independently
      step(1, 0, 0, 0, 0, 20, 1, 0, 0, 32'h0,      4'd0, "dup_a");
      step(1, 0, 0, 0, 0, 20, 1, 0, 0, 32'h1 << 20, 4'd0, "dup_b");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 20, 4'd0, "dup_c");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 20, 4'd0, "dup_d");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,       4'd0, "dup_empty");

      // Dual sources hitting different slots
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 32'h0,                       4'd0, "dual_p3");
      step(1, 0, 0, 0, 0, 4, 1, 0, 0, 32'h1 << 3,                  4'd0, "dual_p4");
      step(1, 3, 1, 4, 1, 10, 1, 0, 1, (32'h1 << 3) | (32'h1 << 4), 4'd0, "dual_stall1");
      step(1, 3, 1, 4, 1, 10, 1, 0, 1, 32'h1 << 4,                 4'd1, "dual_stall2");
      step(1, 3, 1, 4, 1, 10, 1, 0, 0, 32'h0,                      4'd2, "dual_issue");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 10,                 4'd2, "dual_drain1");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 10,                 4'd2, "dual_drain2");
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,                       4'd2, "dual_empty");

      // Flush kills the decode instruction and the youngest in-flight entry
      step(1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h0,       4'd2, "fl_prod");
      step(1, 7, 1, 0, 0, 8, 1, 1, 0, 32'h1 << 7,  4'd2, "fl_flush");
      step(1, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,       4'd2, "fl_after");

      // Saturation: a self-dependent instruction stalls two of every three cycles
      exp_cnt = 4'd2;
      step(1, 0, 0, 0, 0, 13, 1, 0, 0, 32'h0, exp_cnt, "sat_prod");
      for (int i = 0; i < 30; i++) begin
         logic s;
         s = ((i % 3) != 2);
         step(1, 13, 1, 0, 0, 13, 1, 0, s, s ? (32'h1 << 13) : 32'h0, exp_cnt, "sat_loop");
         if (s && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1 << 13, 4'hF, "sat_hold");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Issue controller for the in-order RISC-V pipeline. Tracks destination registers of in-flight instructions between decode and register-file writeback.
- Stalls decode on read-after-write hazards and drives bubble insertion into the decode pipeline register.
- Honours a redirect flush.
- Sits beside the decoder and register file. It sequences issue only and never touches operand data.

Parameters:
- LAT, 2: cycles from issue until the register-file write edge (number of scoreboard slots); legal 1..4.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decoder holds a valid instruction
- dec_rs1_sel  in  5  source register 1 index
- dec_rs2_sel  in  5  source register 2 index
- dec_rs1_used  in  1  instruction reads rs1
- dec_rs2_used  in  1  instruction reads rs2
- dec_rd_sel  in  5  destination register index
- dec_wen  in  1  instruction writes rd
- flush  in  1  redirect: kill decode instruction and youngest in-flight slot
- stall  out  1  hold PC and instruction register this cycle
- issue  out  1  decode instruction advances this cycle
- bubble  out  1  load NOP (write_enable=0) into decode pipeline register
- pending_mask  out  32  bit r set when register r has a write in flight
- stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- State: LAT slots, each {v, rd}. Slot 0 is youngest; slot LAT-1 performs its register write at the end of the current cycle.
- pending(r) = OR over slots of (v && rd==r). pending_mask is that vector; bit 0 is forced to 0. All slots count as pending, including LAT-1, because the register file is not write-through.
- hazard = (dec_rs1_used && rs1!=0 && pending(rs1)) || (dec_rs2_used && rs2!=0 && pending(rs2)).
- Combinational outputs, derived from current state and inputs only, zero-cycle latency:
  - stall = dec_valid && hazard && !flush
  - issue = dec_valid && !hazard && !flush
  - bubble = !issue
- Every clock edge, slots shift one position toward LAT-1; slot LAT-1 content is discarded.
- New slot 0 = {issue && dec_wen && rd!=0, dec_rd_sel}. rd=0 never creates a pending entry.
- On flush:
  - the decode instruction is not issued (new slot 0 invalid);
  - the entry moving from old slot 0 into slot 1 has v cleared;
  - older entries (old slots 1..LAT-2) shift normally and still retire.
  - LAT=1: flush only blocks issue.
- stall_count: increments by 1 on each edge where stall=1; saturates at all-ones and holds.
- Maximum consecutive stall cycles for one dependency = LAT. No deadlock is possible because slots always drain.
- Same-cycle events:
  - An issuing instruction may target a register already pending; both entries are tracked independently.
  - A hazard on an entry retiring this cycle still stalls; the next cycle is hazard-free.
- Reset (any time, including mid-stall): asynchronously clears all slots and stall_count. Outputs then read stall=0, issue=dec_valid, pending_mask=0, stall_count=0.
- Both hazard terms are evaluated in parallel; rs1 and rs2 may hit different slots. The stall lasts until the later one retires.

Test Plan:
- Reset: assert rst mid-operation with slot 0 holding rd=5 → pending_mask=0, stall_count=0, stall=0 immediately, without waiting for a clock edge.
- RAW, LAT=2: cycle0 issue rd=5 wen; cycle1 decode rs1=5 used → stall=1, bubble=1 in cycles 1 and 2; cycle3 stall=0, issue=1; stall_count=2.
- x0 and unused operands:
  - issue rd=0 wen, then a reader of rs1=0 → no stall, pending_mask=0;
  - issue rd=9, then rs2=9 with dec_rs2_used=0 → no stall.
- Dual sources, LAT=2: cycle0 issue rd=3, cycle1 issue rd=4 (independent); cycle2 decode rs1=3 used, rs2=4 used → stall in cycles 2 and 3 only, issue in cycle 4.
- Flush, LAT=2: cycle0 issue rd=7; cycle1 flush=1 with a dependent rs1=7 decode → issue=0, stall=0, bubble=1; cycle2 pending_mask[7]=0, and a rs1=7 reader issues.
- Saturation, CNT_W=4: hold a stalling condition for 20 cycles by re-issuing dependent producers → stall_count reaches 15 and holds.
